// File: rtl/clks_alot_generator_pkg.sv
// Shared clks_alot types: generator FSM states, rate bundle and the
// published clock_state_s used by both the recovery and generator paths.
package clks_alot_p;

    localparam int COUNTER_WIDTH = 32;

    typedef enum logic [1:0] {
        GEN_IDLE,
        GEN_HIGH,
        GEN_LOW,
        GEN_PAUSED
    } gen_state_e;

    typedef struct packed {
        logic [COUNTER_WIDTH-1:0] high_rate_m1;
        logic [COUNTER_WIDTH-1:0] low_rate_m1;
        logic                     even_50_50_en;
    } gen_rates_s;

    typedef struct packed {
        logic rising_edge;
        logic steady_high;
        logic falling_edge;
        logic steady_low;
    } generated_events_s;

    typedef struct packed {
        logic                     pause_active;
        logic [COUNTER_WIDTH-1:0] pause_duration;
        logic                     locked;
    } status_s;

    typedef struct packed {
        logic              clk;
        status_s           status;
        generated_events_s events;
    } clock_state_s;

    function automatic logic [COUNTER_WIDTH-1:0] low_phase_m1(
        input gen_rates_s r
    );
        return r.even_50_50_en ? r.high_rate_m1 : r.low_rate_m1;
    endfunction

    // Whole period minus one; saturates if it cannot fit the counter.
    function automatic logic [COUNTER_WIDTH-1:0] period_m1(
        input gen_rates_s r
    );
        logic [COUNTER_WIDTH:0] s;
        s = {1'b0, r.high_rate_m1}
          + {1'b0, low_phase_m1(r)}
          + {{COUNTER_WIDTH{1'b0}}, 1'b1};
        return s[COUNTER_WIDTH] ? '1 : s[COUNTER_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/clks_alot_generator_half_counter.sv
// Loadable down-counter with a zero flag; stops at zero.
// Load has priority over counting.
module clks_alot_half_counter
    import clks_alot_p::*;
#(
    parameter int WIDTH = COUNTER_WIDTH
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/clks_alot_generator.sv
// Programmable clock generator with runt-free stop and pause.
// Define CLKS_ALOT_GEN_PAUSE_COUNT_EN to count periods spent paused.
module clks_alot_generator
    import clks_alot_p::*;
(
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic                     enable_i,
    input  logic                     pause_req_i,
    input  logic                     even_50_50_en_i,
    input  logic [COUNTER_WIDTH-1:0] high_rate_m1_i,
    input  logic [COUNTER_WIDTH-1:0] low_rate_m1_i,
    input  logic                     conf_load_i,
    output clock_state_s             clock_state_o
);

    gen_state_e        state_q;
    gen_state_e        state_d;
    gen_rates_s        shadow_q;
    gen_rates_s        active_q;
    logic              stop_q;
    logic              clk_q;
    logic              locked_q;
    logic              pause_q;
    logic [COUNTER_WIDTH-1:0] dur_q;
    generated_events_s ev_q;
    generated_events_s ev_d;

    logic              ph_zero;
    logic              ph_load;
    logic [COUNTER_WIDTH-1:0] ph_val;
    logic              enter_high;
    logic              stay_high;
    logic              enter_low;
    logic              stay_low;
    logic              running;

    assign running = (state_q == GEN_HIGH) || (state_q == GEN_LOW);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            GEN_IDLE: begin
                if (enable_i) state_d = GEN_HIGH;
            end
            GEN_HIGH: begin
                if (ph_zero) state_d = GEN_LOW;
            end
            GEN_LOW: begin
                if (ph_zero) begin
                    if (!enable_i || stop_q) state_d = GEN_IDLE;
                    else if (pause_req_i)    state_d = GEN_PAUSED;
                    else                     state_d = GEN_HIGH;
                end
            end
            GEN_PAUSED: begin
                if (!enable_i)         state_d = GEN_IDLE;
                else if (!pause_req_i) state_d = GEN_HIGH;
            end
            default: state_d = GEN_IDLE;
        endcase
    end

    always_comb begin
        enter_high = (state_d == GEN_HIGH) && (state_q != GEN_HIGH);
        stay_high  = (state_d == GEN_HIGH) && (state_q == GEN_HIGH);
        enter_low  = (state_d == GEN_LOW) && (state_q != GEN_LOW);
        stay_low   = ((state_d == GEN_LOW) && (state_q == GEN_LOW))
                   || (state_d == GEN_PAUSED);
        ev_d = '0;
        unique case (1'b1)
            enter_high: ev_d.rising_edge  = 1'b1;
            stay_high:  ev_d.steady_high  = 1'b1;
            enter_low:  ev_d.falling_edge = 1'b1;
            stay_low:   ev_d.steady_low   = 1'b1;
            default:    ev_d = '0;
        endcase
    end

    // The HIGH phase length comes from the shadow being applied this edge.
    always_comb begin
        ph_load = enter_high || enter_low;
        ph_val  = enter_high ? shadow_q.high_rate_m1
                             : low_phase_m1(active_q);
    end

    clks_alot_half_counter #(
        .WIDTH    (COUNTER_WIDTH)
    ) u_phase_cnt (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .load     (ph_load),
        .load_val (ph_val),
        .zero     (ph_zero)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q  <= GEN_IDLE;
            shadow_q <= '0;
            active_q <= '0;
            stop_q   <= 1'b0;
            clk_q    <= 1'b0;
            ev_q     <= '0;
            locked_q <= 1'b0;
            pause_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (conf_load_i) begin
                shadow_q.high_rate_m1  <= high_rate_m1_i;
                shadow_q.low_rate_m1   <= low_rate_m1_i;
                shadow_q.even_50_50_en <= even_50_50_en_i;
            end
            if (enter_high) active_q <= shadow_q;
            // A disable seen mid-period sticks until the period ends.
            if (state_d == GEN_IDLE)       stop_q <= 1'b0;
            else if (running && !enable_i) stop_q <= 1'b1;
            clk_q   <= (state_d == GEN_HIGH);
            ev_q    <= ev_d;
            pause_q <= (state_d == GEN_PAUSED);
            if ((state_d == GEN_IDLE) || (state_d == GEN_PAUSED)) begin
                locked_q <= 1'b0;
            end else if (enter_high && (state_q == GEN_LOW)) begin
                locked_q <= (shadow_q == active_q);
            end
        end
    end

`ifdef CLKS_ALOT_GEN_PAUSE_COUNT_EN
    logic pc_load;
    logic pc_zero;

    assign pc_load = (state_d == GEN_PAUSED)
                   && ((state_q != GEN_PAUSED) || pc_zero);

    clks_alot_half_counter #(
        .WIDTH    (COUNTER_WIDTH)
    ) u_pause_cnt (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .load     (pc_load),
        .load_val (period_m1(active_q)),
        .zero     (pc_zero)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            dur_q <= '0;
        end else if ((state_d == GEN_PAUSED)
                     && (state_q != GEN_PAUSED)) begin
            dur_q <= '0;
        end else if ((state_q == GEN_PAUSED) && pc_zero
                     && (dur_q != '1)) begin
            dur_q <= dur_q + COUNTER_WIDTH'(1);
        end
    end
`else
    assign dur_q = '0;
`endif

    always_comb begin
        clock_state_o                       = '0;
        clock_state_o.clk                   = clk_q;
        clock_state_o.events                = ev_q;
        clock_state_o.status.locked         = locked_q;
        clock_state_o.status.pause_active   = pause_q;
        clock_state_o.status.pause_duration = dur_q;
    end

endmodule

// File: tb/tb_clks_alot_generator.sv
// Directed bench for clks_alot_generator: per-cycle expectations are
// queued at each negedge and checked just after the following posedge.
module tb_clks_alot_generator;
    import clks_alot_p::*;

    localparam logic [3:0] EV_0  = 4'b0000;
    localparam logic [3:0] EV_R  = 4'b1000;
    localparam logic [3:0] EV_SH = 4'b0100;
    localparam logic [3:0] EV_F  = 4'b0010;
    localparam logic [3:0] EV_SL = 4'b0001;
`ifdef CLKS_ALOT_GEN_PAUSE_COUNT_EN
    localparam bit PC_EN = 1'b1;
`else
    localparam bit PC_EN = 1'b0;
`endif

    typedef struct {
        logic [6:0]  v;
        logic        dchk;
        logic [31:0] dur;
    } item_t;

    logic sys_clk = 1'b0;
    logic sys_rst;
    logic enable_i;
    logic pause_req_i;
    logic even_50_50_en_i;
    logic [COUNTER_WIDTH-1:0] high_rate_m1_i;
    logic [COUNTER_WIDTH-1:0] low_rate_m1_i;
    logic conf_load_i;
    clock_state_s clock_state_o;

    item_t exp_q[$];
    string tag_q[$];
    int    total = 0;
    int    bad   = 0;

    clks_alot_generator dut (
        .sys_clk         (sys_clk),
        .sys_rst         (sys_rst),
        .enable_i        (enable_i),
        .pause_req_i     (pause_req_i),
        .even_50_50_en_i (even_50_50_en_i),
        .high_rate_m1_i  (high_rate_m1_i),
        .low_rate_m1_i   (low_rate_m1_i),
        .conf_load_i     (conf_load_i),
        .clock_state_o   (clock_state_o)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) begin
        #1;
        if (exp_q.size() != 0) begin
            item_t      e;
            string      t;
            logic [6:0] obs;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            obs = {clock_state_o.clk,
                   clock_state_o.events.rising_edge,
                   clock_state_o.events.steady_high,
                   clock_state_o.events.falling_edge,
                   clock_state_o.events.steady_low,
                   clock_state_o.status.locked,
                   clock_state_o.status.pause_active};
            total++;
            assert (obs === e.v) else begin
                bad++;
                $error("FAIL %s clk/r/sh/f/sl/lk/pa obs=%b exp=%b",
                       t, obs, e.v);
            end
            if (e.dchk) begin
                total++;
                assert (clock_state_o.status.pause_duration === e.dur)
                else begin
                    bad++;
                    $error("FAIL %s pause_duration obs=%0d exp=%0d", t,
                           clock_state_o.status.pause_duration, e.dur);
                end
            end
        end
    end

    // Queue the state expected after the next posedge, then advance.
    task automatic push(input string tag, input logic c,
                        input logic [3:0] ev, input logic lk,
                        input logic pa, input logic dchk,
                        input logic [31:0] dur);
        item_t e;
        e.v    = {c, ev, lk, pa};
        e.dchk = dchk;
        e.dur  = dur;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge sys_clk);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) push(tag, 1'b0, EV_0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic run_periods(input string tag, input int h,
                               input int l, input int n,
                               input logic lk0, input logic lk1);
        for (int p = 0; p < n; p++) begin
            logic lk;
            lk = (p == 0) ? lk0 : lk1;
            for (int c = 0; c <= h; c++)
                push(tag, 1'b1, (c == 0) ? EV_R : EV_SH, lk, 1'b0, 1'b0, 0);
            for (int c = 0; c <= l; c++)
                push(tag, 1'b0, (c == 0) ? EV_F : EV_SL, lk, 1'b0, 1'b0, 0);
        end
    endtask

    task automatic load(input int h, input int l, input logic ev50);
        high_rate_m1_i  = h;
        low_rate_m1_i   = l;
        even_50_50_en_i = ev50;
        conf_load_i     = 1'b1;
        idle("load", 1);
        conf_load_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        sys_rst = 1'b1;
        enable_i = 1'b0;
        pause_req_i = 1'b0;
        even_50_50_en_i = 1'b0;
        high_rate_m1_i = '0;
        low_rate_m1_i = '0;
        conf_load_i = 1'b0;
        @(negedge sys_clk);
        for (int i = 0; i < 2; i++)
            push("reset", 1'b0, EV_0, 1'b0, 1'b0, 1'b1, 0);
        sys_rst = 1'b0;
        idle("idle", 2);

        // Basic run: 11100, locked from the 2nd rising edge.
        load(2, 1, 1'b0);
        enable_i = 1'b1;
        run_periods("basic", 2, 1, 3, 1'b0, 1'b1);
        enable_i = 1'b0;
        idle("stop_basic", 1);

        // Minimum rates: toggle every cycle.
        load(0, 0, 1'b0);
        enable_i = 1'b1;
        run_periods("min", 0, 0, 4, 1'b0, 1'b1);
        enable_i = 1'b0;
        idle("stop_min", 1);

        // 50/50 mode ignores the low rate.
        load(3, 9, 1'b1);
        enable_i = 1'b1;
        run_periods("even", 3, 3, 2, 1'b0, 1'b1);
        enable_i = 1'b0;
        idle("stop_even", 1);

        // Mid-HIGH conf_load applies at the next rising edge.
        load(2, 1, 1'b0);
        enable_i = 1'b1;
        run_periods("pre_cfg", 2, 1, 2, 1'b0, 1'b1);
        push("cfg_cur", 1'b1, EV_R, 1'b1, 1'b0, 1'b0, 0);
        high_rate_m1_i = 5;
        conf_load_i = 1'b1;
        push("cfg_cur", 1'b1, EV_SH, 1'b1, 1'b0, 1'b0, 0);
        conf_load_i = 1'b0;
        push("cfg_cur", 1'b1, EV_SH, 1'b1, 1'b0, 1'b0, 0);
        push("cfg_cur", 1'b0, EV_F, 1'b1, 1'b0, 1'b0, 0);
        push("cfg_cur", 1'b0, EV_SL, 1'b1, 1'b0, 1'b0, 0);
        run_periods("cfg_new", 5, 1, 2, 1'b0, 1'b1);

        // Disable mid-HIGH, re-enable in the LOW tail.
        push("stop_r", 1'b1, EV_R, 1'b1, 1'b0, 1'b0, 0);
        enable_i = 1'b0;
        for (int i = 0; i < 5; i++)
            push("stop_h", 1'b1, EV_SH, 1'b1, 1'b0, 1'b0, 0);
        push("stop_f", 1'b0, EV_F, 1'b1, 1'b0, 1'b0, 0);
        enable_i = 1'b1;
        push("stop_sl", 1'b0, EV_SL, 1'b1, 1'b0, 1'b0, 0);
        idle("stop_idle", 1);
        run_periods("restart", 5, 1, 2, 1'b0, 1'b1);
        enable_i = 1'b0;
        idle("stop_re", 1);

        // Pause requested mid-HIGH; 12 cycles parked.
        load(1, 1, 1'b0);
        enable_i = 1'b1;
        run_periods("pre_pause", 1, 1, 2, 1'b0, 1'b1);
        push("pz_r", 1'b1, EV_R, 1'b1, 1'b0, 1'b0, 0);
        pause_req_i = 1'b1;
        push("pz_h", 1'b1, EV_SH, 1'b1, 1'b0, 1'b0, 0);
        push("pz_f", 1'b0, EV_F, 1'b1, 1'b0, 1'b0, 0);
        push("pz_sl", 1'b0, EV_SL, 1'b1, 1'b0, 1'b0, 0);
        for (int k = 1; k <= 12; k++)
            push("paused", 1'b0, EV_SL, 1'b0, 1'b1, 1'b1,
                 PC_EN ? (k - 1) / 4 : 0);
        pause_req_i = 1'b0;
        push("pz_exit", 1'b1, EV_R, 1'b0, 1'b0, 1'b1, PC_EN ? 3 : 0);
        push("pz_hold", 1'b1, EV_SH, 1'b0, 1'b0, 1'b1, PC_EN ? 3 : 0);
        push("pz_hold", 1'b0, EV_F, 1'b0, 1'b0, 1'b1, PC_EN ? 3 : 0);
        push("pz_hold", 1'b0, EV_SL, 1'b0, 1'b0, 1'b1, PC_EN ? 3 : 0);
        push("pz_lock", 1'b1, EV_R, 1'b1, 1'b0, 1'b1, PC_EN ? 3 : 0);

        // Reset mid-HIGH; shadow rates also return to zero.
        sys_rst = 1'b1;
        enable_i = 1'b0;
        push("rst_mid", 1'b0, EV_0, 1'b0, 1'b0, 1'b1, 0);
        sys_rst = 1'b0;
        idle("rst_idle", 3);
        enable_i = 1'b1;
        run_periods("rst_run", 0, 0, 3, 1'b0, 1'b1);
        enable_i = 1'b0;
        idle("end", 1);

        @(posedge sys_clk);
        #2;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
